// File: rtl/symbol_trigger_gen.sv
// Symbol-start trigger generator: tracks sample/symbol/slot position and pulses dout_trigger per symbol.
// Optional run-time realignment on time_sync is enabled by defining SYMBOL_ALIGN_CHECK_EN.
module symbol_trigger_gen #(
  parameter int unsigned FFT_SIZE        = 4096,
  parameter int unsigned CP_LEN1         = 352,
  parameter int unsigned CP_LEN2         = 288,
  parameter int unsigned SYMS_PER_SLOT   = 14,
  parameter int unsigned SLOTS_PER_FRAME = 20,
  parameter int unsigned TRIG_HIGH       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        time_sync,
  input  logic        sync_mode,
  input  logic        sample_valid,
  output logic        dout_trigger,
  output logic        long_cp,
  output logic        dout_sync,
  output logic [3:0]  symbol_index,
  output logic [4:0]  slot_index,
  output logic [12:0] sample_count,
  output logic        frame_end,
  output logic        align_err
);

  typedef enum logic [1:0] {IDLE, WAIT_SYNC, RUN} state_t;

  localparam logic [12:0] LEN_LONG  = 13'(CP_LEN1 + FFT_SIZE);
  localparam logic [12:0] LEN_SHORT = 13'(CP_LEN2 + FFT_SIZE);
  localparam logic [3:0]  SYM_LAST  = 4'(SYMS_PER_SLOT - 1);
  localparam logic [4:0]  SLOT_LAST = 5'(SLOTS_PER_FRAME - 1);
  localparam logic [12:0] TRIG_LOAD = 13'(TRIG_HIGH - 1);

  state_t      r_state, w_next;
  logic [12:0] r_cnt, r_trig_left;
  logic [3:0]  r_sym;
  logic [4:0]  r_slot;
  logic        r_trig, r_long, r_sync, r_frame_end, r_align_err;

  logic [12:0] w_len;
  logic        w_wrap, w_enter, w_realign, w_sym_last, w_slot_last;

  assign w_len       = (r_sym == '0) ? LEN_LONG : LEN_SHORT;
  assign w_sym_last  = (r_sym == SYM_LAST);
  assign w_slot_last = (r_slot == SLOT_LAST);
  assign w_wrap      = (r_state == RUN) && sample_valid && (r_cnt == w_len - 13'd1);
  assign w_enter     = (r_state == WAIT_SYNC) && enable && time_sync;

`ifdef SYMBOL_ALIGN_CHECK_EN
  // A time_sync landing exactly on the frame boundary is already aligned and is ignored.
  assign w_realign = (r_state == RUN) && enable && time_sync &&
                     ((r_cnt != '0) || (r_sym != '0) || (r_slot != '0));
`else
  assign w_realign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!enable) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:      w_next = WAIT_SYNC;
        WAIT_SYNC: if (time_sync) w_next = RUN;
        RUN:       w_next = RUN;
        default:   w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_sym       <= '0;
      r_slot      <= '0;
      r_trig      <= 1'b0;
      r_trig_left <= '0;
      r_long      <= 1'b0;
      r_sync      <= 1'b0;
      r_frame_end <= 1'b0;
      r_align_err <= 1'b0;
    end else if (w_next != RUN) begin
      r_cnt       <= '0;
      r_sym       <= '0;
      r_slot      <= '0;
      r_trig      <= 1'b0;
      r_trig_left <= '0;
      r_long      <= 1'b0;
      r_frame_end <= 1'b0;
      r_align_err <= 1'b0;
    end else if (w_enter || w_realign) begin
      // Realignment wins over a coincident symbol wrap.
      r_cnt       <= '0;
      r_sym       <= '0;
      r_slot      <= '0;
      r_trig      <= 1'b1;
      r_trig_left <= TRIG_LOAD;
      r_long      <= 1'b1;
      r_frame_end <= 1'b0;
      r_align_err <= w_realign;
      if (w_enter) r_sync <= sync_mode;
    end else begin
      r_align_err <= 1'b0;
      r_frame_end <= w_wrap && w_sym_last && w_slot_last;
      if (w_wrap) begin
        r_cnt       <= '0;
        r_trig      <= 1'b1;
        r_trig_left <= TRIG_LOAD;
        if (w_sym_last) begin
          r_sym  <= '0;
          r_long <= 1'b1;
          r_slot <= w_slot_last ? '0 : r_slot + 5'd1;
        end else begin
          r_sym  <= r_sym + 4'd1;
          r_long <= 1'b0;
        end
      end else begin
        if (sample_valid) r_cnt <= r_cnt + 13'd1;
        if (r_trig) begin
          if (r_trig_left == '0) r_trig <= 1'b0;
          else                   r_trig_left <= r_trig_left - 13'd1;
        end
      end
    end
  end

  assign dout_trigger = r_trig;
  assign long_cp      = r_long;
  assign dout_sync    = r_sync;
  assign symbol_index = r_sym;
  assign slot_index   = r_slot;
  assign sample_count = r_cnt;
  assign frame_end    = r_frame_end;
  assign align_err    = r_align_err;

endmodule

// File: tb/tb_symbol_trigger_gen.sv
// Bench for symbol_trigger_gen with shrunk symbol sizes; honours SYMBOL_ALIGN_CHECK_EN like the RTL.
module tb_symbol_trigger_gen;

  localparam int L1 = 22, L2 = 20, SYMS = 14, SLOTS = 20, TH = 4;
  localparam int SLOT_LEN = 282, FRAME_LEN = 5640;
`ifdef SYMBOL_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic enable = 1'b0, time_sync = 1'b0, sync_mode = 1'b0, sample_valid = 1'b0;
  logic dout_trigger, long_cp, dout_sync, frame_end, align_err;
  logic [3:0]  symbol_index;
  logic [4:0]  slot_index;
  logic [12:0] sample_count;

  int checks = 0, failures = 0;
  int m_st, m_cnt, m_sym, m_slot, m_tl;
  bit m_sync, m_fe, m_ae;
  int rise [0:299];
  bit long_at [0:299];
  int n_rise, fe_n, fe_at;
  bit prev_trig;

  symbol_trigger_gen #(
    .FFT_SIZE(16), .CP_LEN1(6), .CP_LEN2(4),
    .SYMS_PER_SLOT(14), .SLOTS_PER_FRAME(20), .TRIG_HIGH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .time_sync(time_sync),
    .sync_mode(sync_mode), .sample_valid(sample_valid),
    .dout_trigger(dout_trigger), .long_cp(long_cp), .dout_sync(dout_sync),
    .symbol_index(symbol_index), .slot_index(slot_index),
    .sample_count(sample_count), .frame_end(frame_end), .align_err(align_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en, ts, sv, sm;
    logic e_trig, e_long, e_sync;
    int   e_cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int len_of(input int s);
    return (s == 0) ? L1 : L2;
  endfunction

  function automatic logic [31:0] outs();
    return {5'd0, dout_trigger, long_cp, dout_sync, align_err, frame_end,
            slot_index, symbol_index, sample_count};
  endfunction

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_sym = 0; m_slot = 0; m_tl = 0;
    m_sync = 0; m_fe = 0; m_ae = 0;
  endtask

  task automatic check_model();
    logic [31:0] e;
    e = {5'd0, logic'(m_tl > 0), logic'(m_st == 2 && m_sym == 0), m_sync, m_ae, m_fe,
         5'(m_slot), 4'(m_sym), 13'(m_cnt)};
    chk("model", outs(), e);
  endtask

  task automatic step(input logic en, input logic ts, input logic sv, input logic sm);
    enable = en; time_sync = ts; sample_valid = sv; sync_mode = sm;
    @(posedge clk); #1;
    m_fe = 0; m_ae = 0;
    if (!en) begin
      m_st = 0; m_cnt = 0; m_sym = 0; m_slot = 0; m_tl = 0;
    end else if (m_st == 0) begin
      m_st = 1;
    end else if (m_st == 1) begin
      if (ts) begin
        m_st = 2; m_cnt = 0; m_sym = 0; m_slot = 0; m_sync = sm; m_tl = TH;
      end
    end else begin
      if (ts && ALIGN && (m_cnt != 0 || m_sym != 0 || m_slot != 0)) begin
        m_cnt = 0; m_sym = 0; m_slot = 0; m_ae = 1; m_tl = TH;
      end else if (sv && m_cnt == len_of(m_sym) - 1) begin
        m_fe = (m_sym == SYMS - 1) && (m_slot == SLOTS - 1);
        m_cnt = 0; m_tl = TH;
        if (m_sym == SYMS - 1) begin
          m_sym = 0;
          m_slot = (m_slot == SLOTS - 1) ? 0 : m_slot + 1;
        end else m_sym = m_sym + 1;
      end else begin
        if (sv) m_cnt = m_cnt + 1;
        if (m_tl > 0) m_tl = m_tl - 1;
      end
    end
    check_model();
  endtask

  task automatic rec_clear();
    n_rise = 0; fe_n = 0; fe_at = -1; prev_trig = 1'b0;
    for (int i = 0; i < 300; i++) begin rise[i] = -1; long_at[i] = 1'b0; end
  endtask

  task automatic rec(input int k);
    if (dout_trigger && !prev_trig && n_rise < 300) begin
      rise[n_rise] = k; long_at[n_rise] = long_cp; n_rise++;
    end
    prev_trig = dout_trigger;
    if (frame_end) begin fe_n++; fe_at = k; end
  endtask

  initial begin
    vec_t tbl [13];
    int   sym_before, guard;
    tbl[0]  = '{0,0,0,0, 0,0,0, 0};
    tbl[1]  = '{1,0,0,0, 0,0,0, 0};
    tbl[2]  = '{1,0,1,0, 0,0,0, 0};
    tbl[3]  = '{1,1,1,1, 1,1,1, 0};
    tbl[4]  = '{1,0,1,0, 1,1,1, 1};
    tbl[5]  = '{1,0,0,0, 1,1,1, 1};
    tbl[6]  = '{1,0,1,0, 1,1,1, 2};
    tbl[7]  = '{1,0,1,0, 0,1,1, 3};
    tbl[8]  = '{1,0,0,0, 0,1,1, 3};
    tbl[9]  = '{0,0,1,0, 0,0,1, 0};
    tbl[10] = '{1,1,1,0, 0,0,1, 0};
    tbl[11] = '{1,1,1,0, 1,1,0, 0};
    tbl[12] = '{0,0,1,0, 0,0,0, 0};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), 32'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].ts, tbl[i].sv, tbl[i].sm);
      chk($sformatf("tbl%0d_trig", i), dout_trigger, tbl[i].e_trig);
      chk($sformatf("tbl%0d_long", i), long_cp, tbl[i].e_long);
      chk($sformatf("tbl%0d_sync", i), dout_sync, tbl[i].e_sync);
      chk($sformatf("tbl%0d_cnt", i), sample_count, tbl[i].e_cnt);
    end

    // Asynchronous reset while the trigger is high.
    step(1, 0, 0, 0);
    step(1, 1, 1, 1);
    step(1, 0, 1, 0);
    rst_n = 1'b0;
    #1;
    chk("reset_async_outputs", outs(), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    rec_clear();
    for (int k = 0; k < 30; k++) begin step(1, 0, 1, 0); rec(k); end
    chk("no_trig_without_sync", n_rise, 0);

    // Full frame with continuous samples.
    rec_clear();
    step(1, 1, 1, 0); rec(0);
    for (int k = 1; k <= FRAME_LEN + 5; k++) begin step(1, 0, 1, 0); rec(k); end
    chk("frame_rise0", rise[0], 0);
    chk("frame_rise1", rise[1], L1);
    chk("frame_rise2", rise[2], L1 + L2);
    chk("frame_slot_span", rise[14], SLOT_LEN);
    chk("frame_span", rise[280], FRAME_LEN);
    chk("frame_long0", long_at[0], 1);
    chk("frame_long1", long_at[1], 0);
    chk("frame_long14", long_at[14], 1);
    chk("frame_long_next", long_at[280], 1);
    chk("frame_end_count", fe_n, 1);
    chk("frame_end_at", fe_at, FRAME_LEN);

    // 50% sample_valid duty.
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    rec_clear();
    step(1, 1, 0, 0); rec(0);
    for (int k = 1; k <= 130; k++) begin step(1, 0, logic'(k % 2 == 0), 0); rec(k); end
    chk("duty_rise1", rise[1], 2 * L1);
    chk("duty_rise2", rise[2], 2 * L1 + 2 * L2);
    chk("duty_rise3", rise[3], 2 * L1 + 4 * L2);

    // time_sync in RUN, off the boundary.
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 1, 0);
    for (int k = 1; k <= 50; k++) step(1, 0, 1, 0);
    chk("pre_align_pos", {symbol_index, sample_count}, {4'd2, 13'd8});
    step(1, 1, 1, 0);
`ifdef SYMBOL_ALIGN_CHECK_EN
    chk("align_err_pulse", align_err, 1);
    chk("align_restart", {dout_trigger, long_cp, symbol_index, sample_count}, {2'b11, 4'd0, 13'd0});
    step(1, 1, 1, 0);
    chk("align_boundary_quiet", {align_err, sample_count}, {1'b0, 13'd1});
`else
    chk("align_ignored", {align_err, dout_trigger, symbol_index, sample_count}, {2'b00, 4'd2, 13'd9});
    step(1, 1, 1, 0);
    chk("align_err_zero", {align_err, sample_count}, {1'b0, 13'd10});
`endif
    // time_sync coinciding with a symbol wrap.
    guard = 0;
    while (m_cnt != len_of(m_sym) - 1 && guard < 100) begin step(1, 0, 1, 0); guard++; end
    chk("wrap_reached", guard < 100, 1);
    sym_before = m_sym;
    step(1, 1, 1, 0);
`ifdef SYMBOL_ALIGN_CHECK_EN
    chk("coincide_realign", {align_err, dout_trigger, symbol_index, sample_count},
        {2'b11, 4'd0, 13'd0});
`else
    chk("coincide_wrap", {align_err, dout_trigger, symbol_index, sample_count},
        {2'b01, 4'((sym_before + 1) % SYMS), 13'd0});
`endif
    step(0, 0, 1, 0);
    chk("enable_drop_trig", dout_trigger, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
